// File: rtl/pps_interval_generator.sv
// ---------------------------------------------------------------------------
// pps_interval_generator
//
// Counts sample beats and emits a one-cycle tick each time N beats have been
// seen, keeping a running count of ticks ("seconds") since the last start.
// Supports hold (freeze counting), abort (back to idle), restart, and a
// one-shot mode that stops after the first tick.
//
// Ports:
//   axis_aclk       clock, all logic on the rising edge
//   axis_aresetn    asynchronous active-low reset
//   i_sample_valid  one sample beat per high cycle
//   i_start         pulse: (re)start counting, latches i_interval/i_one_shot
//   i_abort         pulse: return to idle, seconds retained
//   i_hold          level: freeze counting while high (RUN <-> HOLD)
//   i_one_shot      level, sampled at start: stop after the first tick
//   i_interval      samples per tick N (0 is treated as 1)
//   o_tick          one-cycle pulse per completed interval
//   o_sec_wrap      one-cycle pulse, coincident with the tick that wraps o_seconds
//   o_seconds       ticks since start
//   o_sample_count  beats counted in the current interval
//   o_busy          high in RUN or HOLD
//   o_hold          high in HOLD
//   o_done          high in DONE
// ---------------------------------------------------------------------------
module pps_interval_generator #(
  parameter int CNT_W = 32,
  parameter int SEC_W = 32
) (
  input  logic             axis_aclk,
  input  logic             axis_aresetn,
  input  logic             i_sample_valid,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_hold,
  input  logic             i_one_shot,
  input  logic [CNT_W-1:0] i_interval,
  output logic             o_tick,
  output logic             o_sec_wrap,
  output logic [SEC_W-1:0] o_seconds,
  output logic [CNT_W-1:0] o_sample_count,
  output logic             o_busy,
  output logic             o_hold,
  output logic             o_done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] n_active;
  logic             one_shot_active;

  // Interval value to be latched at start or at a tick boundary; zero maps to
  // one so that every beat ticks.
  logic [CNT_W-1:0] n_load;
  logic             last_beat;
  logic             running;

  assign n_load    = (i_interval == '0) ? CNT_W'(1) : i_interval;
  assign last_beat = (o_sample_count == n_active - CNT_W'(1));
  assign running   = (state == RUN) || (state == HOLD);

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state           <= IDLE;
      n_active        <= CNT_W'(1);
      one_shot_active <= 1'b0;
      o_tick          <= 1'b0;
      o_sec_wrap      <= 1'b0;
      o_seconds       <= '0;
      o_sample_count  <= '0;
      o_busy          <= 1'b0;
      o_hold          <= 1'b0;
      o_done          <= 1'b0;
    end else begin
      o_tick     <= 1'b0;
      o_sec_wrap <= 1'b0;

      if (i_abort) begin
        // Abort wins over everything; seconds deliberately kept for readout.
        state          <= IDLE;
        o_sample_count <= '0;
        o_busy         <= 1'b0;
        o_hold         <= 1'b0;
        o_done         <= 1'b0;
      end else if (i_start) begin
        // Start from any state, including a restart while running.
        state           <= RUN;
        o_sample_count  <= '0;
        o_seconds       <= '0;
        n_active        <= n_load;
        one_shot_active <= i_one_shot;
        o_busy          <= 1'b1;
        o_hold          <= 1'b0;
        o_done          <= 1'b0;
      end else if (running) begin
        if (i_hold) begin
          // Beats seen while hold is high are dropped, even a completing one.
          state  <= HOLD;
          o_hold <= 1'b1;
        end else begin
          state  <= RUN;
          o_hold <= 1'b0;
          if (i_sample_valid) begin
            if (last_beat) begin
              o_sample_count <= '0;
              o_seconds      <= o_seconds + SEC_W'(1);
              o_tick         <= 1'b1;
              o_sec_wrap     <= &o_seconds;
              // A new interval only takes effect at the tick boundary.
              n_active       <= n_load;
              if (one_shot_active) begin
                state  <= DONE;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end
            end else begin
              o_sample_count <= o_sample_count + CNT_W'(1);
            end
          end
        end
      end
      // IDLE and DONE hold their state: beats and hold are ignored there.
    end
  end

endmodule

// File: doc/pps_interval_generator.md
PPS_INTERVAL_GENERATOR -- requirements
Module: pps_interval_generator

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of sample counter and interval.
REQ-002 SHALL have parameter SEC_W, default 32, width of tick (seconds) counter.
REQ-003 SHALL have axis_aclk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have axis_aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have i_sample_valid  input  1  one sample beat per high cycle.
REQ-006 SHALL have i_start  input  1  pulse; (re)start counting.
REQ-007 SHALL have i_abort  input  1  pulse; return to idle.
REQ-008 SHALL have i_hold  input  1  level; freeze counting.
REQ-009 SHALL have i_one_shot  input  1  level, sampled at start; stop after first tick.
REQ-010 SHALL have i_interval  input  CNT_W  samples per tick, N.
REQ-011 SHALL have o_tick  output  1  one-cycle pulse per completed interval.
REQ-012 SHALL have o_sec_wrap  output  1  one-cycle pulse when o_seconds wraps.
REQ-013 SHALL have o_seconds  output  SEC_W  ticks since start.
REQ-014 SHALL have o_sample_count  output  CNT_W  beats counted in current interval.
REQ-015 SHALL have o_busy  output  1  high in RUN or HOLD.
REQ-016 SHALL have o_hold  output  1  high in HOLD.
REQ-017 SHALL have o_done  output  1  high in DONE.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, HOLD, DONE; all outputs registered.
REQ-019 SHALL, in IDLE or DONE on i_start: enter RUN, clear counter and o_seconds, latch i_interval and i_one_shot into active registers.
REQ-020 SHALL treat latched N=0 as N=1 (tick on every beat).
REQ-021 SHALL, in RUN with i_sample_valid and !i_hold: increment counter; when counter==N-1, clear counter, increment o_seconds, pulse o_tick, reload N from i_interval.
REQ-022 SHALL assert o_tick exactly the cycle after the edge sampling the completing beat (latency 1); o_sample_count likewise registered.
REQ-023 SHALL, on a tick with one-shot latched, enter DONE; valid beats in DONE are ignored.
REQ-024 SHALL move RUN->HOLD when i_hold high, HOLD->RUN when i_hold low; beats while i_hold high are not counted, even on the completing beat.
REQ-025 SHALL, on i_abort in any state, enter IDLE, clear counter; o_seconds retains value.
REQ-026 SHALL give priority abort > start > hold > count in the same cycle.
REQ-027 SHALL treat i_start in RUN/HOLD as restart: counter and o_seconds cleared, N re-latched, state RUN.
REQ-028 SHALL wrap o_seconds from 2^SEC_W-1 to 0 with o_sec_wrap pulsed coincident with that o_tick.
REQ-029 SHALL ignore i_interval changes mid-interval; new value takes effect only at start or tick boundary.
REQ-030 SHALL ignore i_hold in IDLE and DONE.

Reset
REQ-031 SHALL, while axis_aresetn low, force IDLE, counter 0, o_seconds 0, all single-bit outputs 0, active N 1.
REQ-032 SHALL, on reset mid-operation, discard partial interval; first cycle after release is IDLE.

Verification
REQ-033 N=4, valid every cycle after start -> o_tick at cycles 5, 9, 13 after start edge; o_seconds 1,2,3.
REQ-034 N=3, one_shot=1, 10 beats -> single o_tick after beat 3, o_done=1, o_seconds=1 held.
REQ-035 N=5, i_hold high for beats 3-6 of 9 -> o_hold=1 during hold; o_tick after 9th beat only.
REQ-036 SEC_W=2, N=1, 5 beats -> o_seconds 1,2,3,0,1; o_sec_wrap on 4th tick only.
REQ-037 N=4 then i_interval=2 after beat 1 -> next tick after beat 4, following after beat 6.
REQ-038 abort and start same cycle at count 2 -> IDLE, o_busy=0, counter 0, o_seconds retained; reset pulse mid-RUN -> all outputs 0.
